// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: field widths, IDctrl bit positions,
// the ID/EX bundle type and the bubble constant used by hazard logic.
package cpu_pkg;

    localparam int CTRL_W = 8;
    localparam int REG_W  = 4;
    localparam int DATA_W = 16;

    // IDctrl = {regWrite, memRead, memWrite, memToReg, aluSrcImm, aluOp[2:0]}
    localparam int CTRL_REG_WRITE   = 7;
    localparam int CTRL_MEM_READ    = 6;
    localparam int CTRL_MEM_WRITE   = 5;
    localparam int CTRL_MEM_TO_REG  = 4;
    localparam int CTRL_ALU_SRC_IMM = 3;
    localparam int CTRL_ALU_OP_LSB  = 0;
    localparam int ALU_OP_W         = 3;

    typedef logic [REG_W-1:0]  reg_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CTRL_W-1:0] ctrl_t;

    typedef struct packed {
        logic  valid;
        reg_t  r1;
        reg_t  r2;
        reg_t  rd;
        data_t data1;
        data_t data2;
        data_t imm;
        ctrl_t ctrl;
    } id_ex_t;

    // All-zero slot: no register write, no memory access downstream.
    localparam id_ex_t BUBBLE = '0;

    function automatic logic is_load(input ctrl_t c);
        return c[CTRL_MEM_READ];
    endfunction

    function automatic logic writes_reg(input ctrl_t c);
        return c[CTRL_REG_WRITE];
    endfunction

    function automatic logic writes_mem(input ctrl_t c);
        return c[CTRL_MEM_WRITE];
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: flags an ID instruction reading the
// destination of a valid load sitting in EX. Ports: EX state in, ID regs in.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic             ex_valid,
    input  logic [CTRL_W-1:0] ex_ctrl,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_r1,
    input  logic [REG_W-1:0] id_r2,
    output logic             load_use
);

    logic rd_nonzero;
    logic rd_match;

    // Register 0 is hardwired, so a load targeting it never stalls.
    assign rd_nonzero = (ex_rd != '0);
    assign rd_match   = (ex_rd == id_r1) | (ex_rd == id_r2);

    assign load_use = ex_valid & is_load(ex_ctrl) & rd_nonzero
                    & id_valid & rd_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush and EX hold.
// Ports: ID* in, flush/exHold in, EX* out, stallIF out, luStallCnt out.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              IDvalid,
    input  logic [REG_W-1:0]  IDregR1,
    input  logic [REG_W-1:0]  IDregR2,
    input  logic [REG_W-1:0]  IDregRd,
    input  logic [DATA_W-1:0] IDdata1,
    input  logic [DATA_W-1:0] IDdata2,
    input  logic [DATA_W-1:0] IDimm,
    input  logic [CTRL_W-1:0] IDctrl,
    input  logic              flush,
    input  logic              exHold,
    output logic              EXvalid,
    output logic [REG_W-1:0]  EXregR1,
    output logic [REG_W-1:0]  EXregR2,
    output logic [REG_W-1:0]  EXregRd,
    output logic [DATA_W-1:0] EXdata1,
    output logic [DATA_W-1:0] EXdata2,
    output logic [DATA_W-1:0] EXimm,
    output logic [CTRL_W-1:0] EXctrl,
    output logic              stallIF,
    output logic [15:0]       luStallCnt
);

    id_ex_t      ex_q;
    id_ex_t      id_in;
    logic        load_use;
    logic [15:0] lu_cnt;

    hazard_detect u_hazard (
        .ex_valid (ex_q.valid),
        .ex_ctrl  (ex_q.ctrl),
        .ex_rd    (ex_q.rd),
        .id_valid (IDvalid),
        .id_r1    (IDregR1),
        .id_r2    (IDregR2),
        .load_use (load_use)
    );

    // An invalid ID slot is captured as a full bubble.
    always_comb begin
        id_in = BUBBLE;
        if (IDvalid) begin
            id_in.valid = 1'b1;
            id_in.r1    = IDregR1;
            id_in.r2    = IDregR2;
            id_in.rd    = IDregRd;
            id_in.data1 = IDdata1;
            id_in.data2 = IDdata2;
            id_in.imm   = IDimm;
            id_in.ctrl  = IDctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q   <= BUBBLE;
            lu_cnt <= '0;
        end else if (flush) begin
            ex_q <= BUBBLE;
        end else if (exHold) begin
            ex_q <= ex_q;
        end else if (load_use) begin
            // Bubble clears EX valid, so the stall lasts one cycle.
            ex_q <= BUBBLE;
            if (lu_cnt != 16'hFFFF) begin
                lu_cnt <= lu_cnt + 16'd1;
            end
        end else begin
            ex_q <= id_in;
        end
    end

    assign stallIF = (load_use | exHold) & ~flush;

    assign EXvalid    = ex_q.valid;
    assign EXregR1    = ex_q.r1;
    assign EXregR2    = ex_q.r2;
    assign EXregRd    = ex_q.rd;
    assign EXdata1    = ex_q.data1;
    assign EXdata2    = ex_q.data2;
    assign EXimm      = ex_q.imm;
    assign EXctrl     = ex_q.ctrl;
    assign luStallCnt = lu_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage against a behavioural model.
// Ports: none; drives the stage and prints a one-line summary.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        IDvalid = 1'b0;
    logic [3:0]  IDregR1 = '0;
    logic [3:0]  IDregR2 = '0;
    logic [3:0]  IDregRd = '0;
    logic [15:0] IDdata1 = '0;
    logic [15:0] IDdata2 = '0;
    logic [15:0] IDimm = '0;
    logic [7:0]  IDctrl = '0;
    logic        flush = 1'b0;
    logic        exHold = 1'b0;
    logic        EXvalid;
    logic [3:0]  EXregR1;
    logic [3:0]  EXregR2;
    logic [3:0]  EXregRd;
    logic [15:0] EXdata1;
    logic [15:0] EXdata2;
    logic [15:0] EXimm;
    logic [7:0]  EXctrl;
    logic        stallIF;
    logic [15:0] luStallCnt;

    int total = 0;
    int bad = 0;

    // Behavioural model of what EX should hold.
    bit        m_v;
    bit [3:0]  m_r1, m_r2, m_rd;
    bit [15:0] m_d1, m_d2, m_imm;
    bit [7:0]  m_ctrl;
    int        m_cnt;

    logic [68:0] got;

    id_ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .IDvalid    (IDvalid),
        .IDregR1    (IDregR1),
        .IDregR2    (IDregR2),
        .IDregRd    (IDregRd),
        .IDdata1    (IDdata1),
        .IDdata2    (IDdata2),
        .IDimm      (IDimm),
        .IDctrl     (IDctrl),
        .flush      (flush),
        .exHold     (exHold),
        .EXvalid    (EXvalid),
        .EXregR1    (EXregR1),
        .EXregR2    (EXregR2),
        .EXregRd    (EXregRd),
        .EXdata1    (EXdata1),
        .EXdata2    (EXdata2),
        .EXimm      (EXimm),
        .EXctrl     (EXctrl),
        .stallIF    (stallIF),
        .luStallCnt (luStallCnt)
    );

    always #5 clk = ~clk;

    assign got = {EXvalid, EXregR1, EXregR2, EXregRd,
                  EXdata1, EXdata2, EXimm, EXctrl};

    function automatic logic [68:0] exp_vec();
        return {m_v, m_r1, m_r2, m_rd, m_d1, m_d2, m_imm, m_ctrl};
    endfunction

    // An ID instruction depends on a load in EX that writes a real register.
    function automatic bit m_lu();
        bit dep;
        dep = (m_rd == IDregR1) || (m_rd == IDregR2);
        return m_v && m_ctrl[6] && (m_rd != 0) && IDvalid && dep;
    endfunction

    function automatic bit exp_stall();
        return (m_lu() || exHold) && !flush;
    endfunction

    task automatic m_clear();
        m_v = 0; m_r1 = 0; m_r2 = 0; m_rd = 0;
        m_d1 = 0; m_d2 = 0; m_imm = 0; m_ctrl = 0;
    endtask

    // Advance one clock; model follows the stage's priority rules.
    task automatic tick();
        bit lu;
        lu = m_lu();
        @(posedge clk);
        if (rst) begin
            m_clear();
            m_cnt = 0;
        end else if (flush) begin
            m_clear();
        end else if (exHold) begin
            m_v = m_v;
        end else if (lu) begin
            m_clear();
            m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        end else if (IDvalid) begin
            m_v = 1; m_r1 = IDregR1; m_r2 = IDregR2; m_rd = IDregRd;
            m_d1 = IDdata1; m_d2 = IDdata2; m_imm = IDimm; m_ctrl = IDctrl;
        end else begin
            m_clear();
        end
        #1;
    endtask

    task automatic set_id(input bit v, input bit [3:0] r1, input bit [3:0] r2,
                          input bit [3:0] rd, input bit [15:0] d1,
                          input bit [7:0] ctrl);
        IDvalid = v; IDregR1 = r1; IDregR2 = r2; IDregRd = rd;
        IDdata1 = d1; IDdata2 = 16'($urandom); IDimm = 16'($urandom);
        IDctrl = ctrl;
    endtask

    task automatic test_reset();
        rst = 1;
        set_id(1, 1, 2, 3, 16'hAAAA, 8'hFF);
        tick();
        total++;
        if (got !== 69'd0 || luStallCnt !== 16'd0) begin
            bad++;
            $display("FAIL reset: ex=%h cnt=%h need 0", got, luStallCnt);
        end
        rst = 0;
        set_id(0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (stallIF !== 1'b0) begin
            bad++;
            $display("FAIL reset_stall: got %b need 0", stallIF);
        end
    endtask

    task automatic test_capture();
        set_id(1, 3, 4, 5, 16'h1234, 8'h80);
        #1;
        total++;
        if (stallIF !== 1'b0) begin
            bad++;
            $display("FAIL cap_stall: got %b need 0", stallIF);
        end
        tick();
        total++;
        if (got !== exp_vec() || EXdata1 !== 16'h1234 || EXregRd !== 4'd5) begin
            bad++;
            $display("FAIL capture: got %h need %h", got, exp_vec());
        end
    endtask

    task automatic test_load_use();
        int c0;
        c0 = m_cnt;
        set_id(1, 1, 2, 5, 16'h0BAD, 8'hC0);
        #1;
        tick();
        set_id(1, 5, 7, 6, 16'h5555, 8'h80);
        #1;
        total++;
        if (stallIF !== 1'b1) begin
            bad++;
            $display("FAIL lu_stall: got %b need 1", stallIF);
        end
        tick();
        total++;
        if (EXvalid !== 1'b0 || EXctrl !== 8'h00 || got !== exp_vec()
            || luStallCnt !== 16'(c0 + 1)) begin
            bad++;
            $display("FAIL lu_bubble: v=%b ctrl=%h cnt=%0d need 0 0 %0d",
                     EXvalid, EXctrl, luStallCnt, c0 + 1);
        end
        total++;
        if (stallIF !== 1'b0) begin
            bad++;
            $display("FAIL lu_one_cycle: got %b need 0", stallIF);
        end
        tick();
        total++;
        if (got !== exp_vec() || EXdata1 !== 16'h5555 || EXvalid !== 1'b1) begin
            bad++;
            $display("FAIL lu_capture: got %h need %h", got, exp_vec());
        end
    endtask

    task automatic test_r0_load();
        int c0;
        c0 = m_cnt;
        set_id(1, 1, 2, 0, 16'h0000, 8'hC0);
        #1;
        tick();
        set_id(1, 9, 0, 8, 16'h7777, 8'h80);
        #1;
        total++;
        if (stallIF !== 1'b0) begin
            bad++;
            $display("FAIL r0_stall: got %b need 0", stallIF);
        end
        tick();
        total++;
        if (got !== exp_vec() || EXvalid !== 1'b1 || luStallCnt !== 16'(c0)) begin
            bad++;
            $display("FAIL r0_capture: got %h cnt=%0d need %h cnt=%0d",
                     got, luStallCnt, exp_vec(), c0);
        end
    endtask

    task automatic test_flush_priority();
        int c0;
        c0 = m_cnt;
        set_id(1, 1, 2, 5, 16'h1111, 8'hC0);
        #1;
        tick();
        set_id(1, 5, 5, 6, 16'h2222, 8'h80);
        flush = 1;
        exHold = 1;
        #1;
        total++;
        if (stallIF !== 1'b0) begin
            bad++;
            $display("FAIL flush_stall: got %b need 0", stallIF);
        end
        tick();
        total++;
        if (EXvalid !== 1'b0 || got !== 69'd0 || luStallCnt !== 16'(c0)) begin
            bad++;
            $display("FAIL flush_bubble: got %h cnt=%0d need 0 cnt=%0d",
                     got, luStallCnt, c0);
        end
        flush = 0;
        exHold = 0;
    endtask

    task automatic test_hold();
        logic [68:0] held;
        int c0;
        set_id(1, 1, 2, 5, 16'h3333, 8'hC0);
        #1;
        tick();
        held = got;
        c0 = m_cnt;
        exHold = 1;
        for (int i = 0; i < 3; i++) begin
            // First cycle also has a live load-use: hold must win.
            set_id(1, (i == 0) ? 4'd5 : 4'($urandom), 4'($urandom),
                   4'($urandom), 16'($urandom), 8'($urandom));
            #1;
            total++;
            if (stallIF !== 1'b1) begin
                bad++;
                $display("FAIL hold_stall[%0d]: got %b need 1", i, stallIF);
            end
            tick();
            total++;
            if (got !== held || got !== exp_vec() || luStallCnt !== 16'(c0)) begin
                bad++;
                $display("FAIL hold_keep[%0d]: got %h need %h", i, got, held);
            end
        end
        exHold = 0;
        flush = 1;
        #1;
        tick();
        flush = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 63) == 0);
            flush  = ($urandom_range(0, 15) == 0);
            exHold = ($urandom_range(0, 7) == 0);
            set_id($urandom_range(0, 7) != 0,
                   4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)), 16'($urandom),
                   8'($urandom) | (($urandom_range(0, 1) == 1) ? 8'h40 : 8'h00));
            #1;
            total++;
            if (stallIF !== exp_stall()) begin
                bad++;
                $display("FAIL rand_stall[%0d]: got %b need %b",
                         i, stallIF, exp_stall());
            end
            tick();
            total++;
            if (got !== exp_vec() || luStallCnt !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL rand_state[%0d]: got %h/%0d need %h/%0d",
                         i, got, luStallCnt, exp_vec(), m_cnt);
            end
        end
        rst = 0;
        flush = 0;
        exHold = 0;
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut.lu_cnt = 16'hFFFD;
        #1;
        release dut.lu_cnt;
        m_cnt = 65533;
        flush = 1;
        #1;
        tick();
        flush = 0;
        for (int i = 0; i < 4; i++) begin
            set_id(1, 0, 0, 5, 16'h4444, 8'hC0);
            #1;
            tick();
            set_id(1, 5, 1, 2, 16'h6666, 8'h80);
            #1;
            tick();
            total++;
            if (luStallCnt !== 16'(m_cnt) || EXvalid !== 1'b0) begin
                bad++;
                $display("FAIL sat[%0d]: cnt=%h v=%b need %h 0",
                         i, luStallCnt, EXvalid, 16'(m_cnt));
            end
        end
        total++;
        if (luStallCnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_top: got %h need FFFF", luStallCnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        set_id(1, 0, 0, 5, 16'h8888, 8'hC0);
        #1;
        tick();
        set_id(1, 5, 3, 6, 16'h9999, 8'h80);
        exHold = 1;
        rst = 1;
        #1;
        total++;
        if (stallIF !== 1'b1) begin
            bad++;
            $display("FAIL rst_hold_stall: got %b need 1", stallIF);
        end
        tick();
        total++;
        if (got !== 69'd0 || luStallCnt !== 16'd0) begin
            bad++;
            $display("FAIL rst_mid: got %h cnt=%h need 0", got, luStallCnt);
        end
        rst = 0;
        exHold = 0;
        #1;
        total++;
        if (stallIF !== 1'b0) begin
            bad++;
            $display("FAIL rst_residual: got %b need 0", stallIF);
        end
        tick();
        total++;
        if (got !== exp_vec() || EXdata1 !== 16'h9999) begin
            bad++;
            $display("FAIL rst_release: got %h need %h", got, exp_vec());
        end
    endtask

    initial begin
        m_clear();
        m_cnt = 0;
        @(negedge clk);
        test_reset();
        test_capture();
        test_load_use();
        test_r0_load();
        test_flush_priority();
        test_hold();
        test_random();
        test_saturation();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
